matmul_seq_ctrl: RTL and testbench

- FSM controller that computes C = A x B by sequencing one unsigned multiply-accumulate datapath over the single-port data RAM.
- Sits between `top`'s `i_start`/`o_busy` pins and the shared data RAM.
- Reads A (M x N) and B (N x P), both row-major, and writes C (M x P) back into the same RAM.
- Default geometry (3x4 times 4x6) places C at address 0x24, 18 elements.

---
 rtl/matmul_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq_ctrl.sv
// Sequential C = A x B controller driving one unsigned MAC over a single-port synchronous RAM.
// Define MATMUL_SAT_EN to saturate written results instead of wrapping them.
module matmul_seq_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned M      = 3,
  parameter int unsigned N      = 4,
  parameter int unsigned P      = 6,
  parameter int unsigned A_BASE = 0,
  parameter int unsigned B_BASE = 12,
  parameter int unsigned C_BASE = 36
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int unsigned IW    = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned JW    = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned KW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ACC_W = 2 * DATA_W + $clog2(N);

  typedef enum logic [2:0] {StIdle, StFetchA, StFetchB, StMac, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     i_q, i_d;
  logic [JW-1:0]     j_q, j_d;
  logic [KW-1:0]     k_q, k_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] a_reg_q, a_reg_d;
  logic              start_q;
  logic [DATA_W-1:0] result;

`ifdef MATMUL_SAT_EN
  assign result = (|acc_q[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : acc_q[DATA_W-1:0];
`else
  assign result = acc_q[DATA_W-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    acc_d       = acc_q;
    a_reg_d     = a_reg_q;
    o_busy      = (state_q != StIdle);
    o_done      = 1'b0;
    o_ram_addr  = '0;
    o_ram_we    = 1'b0;
    o_ram_wdata = '0;
    unique case (state_q)
      StIdle: begin
        if (i_start && !start_q) begin
          state_d = StFetchA;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      StFetchA: begin
        o_ram_addr = ADDR_W'(A_BASE + N * 32'(i_q) + 32'(k_q));
        state_d    = StFetchB;
      end
      StFetchB: begin
        // rdata now holds the A element addressed in the previous cycle
        o_ram_addr = ADDR_W'(B_BASE + P * 32'(k_q) + 32'(j_q));
        a_reg_d    = i_ram_rdata;
        state_d    = StMac;
      end
      StMac: begin
        acc_d = acc_q + ACC_W'(a_reg_q) * ACC_W'(i_ram_rdata);
        if (k_q == KW'(N - 1)) begin
          state_d = StWrite;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = StFetchA;
        end
      end
      StWrite: begin
        o_ram_addr  = ADDR_W'(C_BASE + P * 32'(i_q) + 32'(j_q));
        o_ram_we    = 1'b1;
        o_ram_wdata = result;
        acc_d       = '0;
        k_d         = '0;
        if (j_q == JW'(P - 1)) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
        if ((i_q == IW'(M - 1)) && (j_q == JW'(P - 1))) state_d = StDone;
        else                                            state_d = StFetchA;
      end
      StDone: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      a_reg_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      a_reg_q <= a_reg_d;
      start_q <= i_start;
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Randomized self-checking bench for matmul_seq_ctrl with a RAM model and a run-level reference.
`timescale 1ps/1ps
module tb_matmul_seq_ctrl;
  localparam int M = 3, N = 4, P = 6, A_BASE = 0, B_BASE = 12, C_BASE = 36;
  localparam int EL = 3 * N + 1;
  localparam int RUN = M * P * EL + 1;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic        busy, done, we;
  logic [15:0] addr;
  logic [7:0]  wdata, rdata;
  logic [7:0]  mem [256];

  always #5 clk = ~clk;

  matmul_seq_ctrl #(
    .ADDR_W(16), .DATA_W(8), .M(M), .N(N), .P(P),
    .A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
    .o_ram_addr(addr), .o_ram_we(we), .o_ram_wdata(wdata), .i_ram_rdata(rdata)
  );

  always @(posedge clk) begin
    if (we) mem[addr[7:0]] <= wdata;
    rdata <= mem[addr[7:0]];
  end

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a run is RUN cycles long; element e owns cycles e*EL .. e*EL+EL-1,
  // where each k uses three cycles (A read, B read, accumulate) and the last cycle writes.
  bit         active = 1'b0, start_prev = 1'b0;
  int         t = 0, run_idx = 0, cyc = 0, done_seen = 0;
  logic [7:0] exp_c [M*P];
  int         lit_addr [9] = '{0, 12, 1, 18, 2, 24, 3, 30, 36};
  int         lit_t    [9] = '{0, 1, 3, 4, 6, 7, 9, 10, 12};

  function automatic logic [7:0] result_of(input int unsigned acc);
`ifdef MATMUL_SAT_EN
    return (acc > 255) ? 8'hFF : acc[7:0];
`else
    return acc[7:0];
`endif
  endfunction

  task automatic snap_c();
    for (int e = 0; e < M * P; e++) begin
      int unsigned acc;
      acc = 0;
      for (int k = 0; k < N; k++)
        acc += int'(mem[A_BASE + (e / P) * N + k]) * int'(mem[B_BASE + k * P + (e % P)]);
      exp_c[e] = result_of(acc);
    end
  endtask

  always @(negedge clk) begin : cmp
    int e, ph;
    cyc++;
    if (cyc > 2) begin
      if (done === 1'b1) done_seen++;
      if (!active) begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_we", we, 0);
        chk("idle_addr", addr, 0);
        chk("idle_wdata", wdata, 0);
      end else begin
        e  = t / EL;
        ph = t % EL;
        chk("run_busy", busy, 1);
        chk("run_done", done, (t == RUN - 1));
        if (t == RUN - 1) begin
          chk("done_we", we, 0);
        end else if (ph == EL - 1) begin
          chk("wr_we", we, 1);
          chk("wr_addr", addr, C_BASE + e);
          chk("wr_data", wdata, exp_c[e]);
        end else begin
          chk("rd_we", we, 0);
          if (ph % 3 == 0) chk("rd_a_addr", addr, A_BASE + (e / P) * N + ph / 3);
          if (ph % 3 == 1) chk("rd_b_addr", addr, B_BASE + (ph / 3) * P + (e % P));
        end
        if (run_idx == 1 && t < EL)
          for (int q = 0; q < 9; q++)
            if (lit_t[q] == t) chk("addr_literal", addr, lit_addr[q]);
      end
    end
    if (rst) begin
      active     = 1'b0;
      start_prev = 1'b0;
    end else begin
      if (active) begin
        if (t == RUN - 1) active = 1'b0;
        else t++;
      end else if (start && !start_prev) begin
        active = 1'b1;
        t      = 0;
        run_idx++;
        snap_c();
      end
      start_prev = start;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int bound);
    int c;
    c = 0;
    while (active && c < bound) begin
      step(1);
      c++;
    end
    chk("run_finishes", active, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
  endtask

  // mode 0: const fill, 1: identity test, 2: random
  task automatic load(input int mode, input logic [7:0] v);
    for (int a = 0; a < 64; a++) mem[a] <= 8'h00;
    for (int i = 0; i < M; i++)
      for (int k = 0; k < N; k++)
        mem[A_BASE + i * N + k] <= (mode == 0) ? v :
                                   (mode == 1) ? 8'(i * 4 + k + 1) : 8'($urandom_range(0, 255));
    for (int k = 0; k < N; k++)
      for (int j = 0; j < P; j++)
        mem[B_BASE + k * P + j] <= (mode == 0) ? v :
                                   (mode == 1) ? ((k == j) ? 8'd1 : 8'd0) :
                                   8'($urandom_range(0, 255));
    step(1);
  endtask

  task automatic check_c(input string name);
    for (int e = 0; e < M * P; e++) chk(name, mem[C_BASE + e], exp_c[e]);
  endtask

  initial begin
    int d0;
    for (int a = 0; a < 256; a++) mem[a] <= 8'h00;
    load(0, 8'h01);
    // start held high across reset release triggers exactly one run
    rst   = 1'b1;
    start = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);
    wait_idle(400);
    start = 1'b0;
    step(3);
    chk("basic_done_count", done_seen, 1);
    for (int e = 0; e < M * P; e++) chk("basic_c_literal", mem[C_BASE + e], 8'h04);

    load(1, 8'h00);
    pulse_start();
    wait_idle(400);
    step(2);
    chk("ident_c23_literal", mem[8'h33], 8'h0C);
    for (int e = 0; e < M * P; e++)
      chk("ident_c", mem[C_BASE + e], ((e % P) < 4) ? ((e / P) * 4 + (e % P) + 1) : 0);

    load(0, 8'hFF);
    pulse_start();
    wait_idle(400);
    step(2);
`ifdef MATMUL_SAT_EN
    for (int e = 0; e < M * P; e++) chk("ovf_c_literal", mem[C_BASE + e], 8'hFF);
`else
    for (int e = 0; e < M * P; e++) chk("ovf_c_literal", mem[C_BASE + e], 8'h04);
`endif

    // level start, short drop, re-raise, then an extra pulse mid-run
    load(0, 8'h01);
    d0    = done_seen;
    start = 1'b1;
    #10000;
    start = 1'b0;
    #50;
    start = 1'b1;
    step(100);
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    wait_idle(400);
    step(300);
    start = 1'b0;
    step(2);
    chk("start_two_runs", done_seen - d0, 2);

    // reset mid-run
    load(2, 8'h00);
    d0 = done_seen;
    pulse_start();
    step(98);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(300);
    chk("reset_no_done", done_seen - d0, 0);
    pulse_start();
    wait_idle(400);
    step(2);
    chk("after_reset_done", done_seen - d0, 1);
    check_c("after_reset_c");

    for (int r = 0; r < 4; r++) begin
      load(2, 8'h00);
      d0 = done_seen;
      pulse_start();
      step($urandom_range(5, 200));
      pulse_start();
      wait_idle(400);
      step(2);
      chk("rand_done", done_seen - d0, 1);
      check_c("rand_c");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
